// File: rtl/dll_rate_update_pkg.sv
// Shared DLL rate-loop definitions (the dll.vh contents) and the package consumed by dll_rate_update.
// The macros live outside the package so channel/increment sizing stays common to all DLL blocks.
`ifndef DLL_VH
`define DLL_VH
`define NUM_CHANNELS        12
`define CHANNEL_ID_WIDTH    4
`define DLL_DPHI_WIDTH      16
`define CA_PHASE_INC_WIDTH  24
`define DLL_CORR_WIDTH      25
`define CA_PHASE_INC_NOM    24'h400000
`define CA_PHASE_INC_MIN    24'h3F0000
`define CA_PHASE_INC_MAX    24'h410000
`endif

package dll_rate_update_pkg;

  localparam int unsigned CHAN_W = `CHANNEL_ID_WIDTH;
  localparam int unsigned DPHI_W = `DLL_DPHI_WIDTH;
  localparam int unsigned INC_W  = `CA_PHASE_INC_WIDTH;
  localparam int unsigned CORR_W = `DLL_CORR_WIDTH;
  // nominal + corr + proportional term needs two growth bits plus a sign bit
  localparam int unsigned SUM_W  = INC_W + 3;

  localparam logic [INC_W-1:0] INC_NOM = `CA_PHASE_INC_NOM;
  localparam logic [INC_W-1:0] INC_MIN = `CA_PHASE_INC_MIN;
  localparam logic [INC_W-1:0] INC_MAX = `CA_PHASE_INC_MAX;

  localparam longint CORR_MIN_L = -(longint'(1) <<< (CORR_W - 1));
  localparam longint CORR_MAX_L = (longint'(1) <<< (CORR_W - 1)) - 1;
  localparam longint INC_MIN_L  = longint'(INC_MIN);
  localparam longint INC_MAX_L  = longint'(INC_MAX);

  typedef struct packed {
    logic [CHAN_W-1:0] tag;
    logic [DPHI_W-1:0] dphi;
    logic [INC_W-1:0]  nom;
    logic [CORR_W-1:0] corr;
  } s1_entry_t;

endpackage

// File: rtl/dll_rate_update_sat.sv
// Signed clamp of a wide value into [MIN_V, MAX_V], narrowed to OUT_W bits, with a clamp flag.
module dll_rate_sat #(
  parameter int unsigned IN_W  = 27,
  parameter int unsigned OUT_W = 24,
  parameter longint      MIN_V = 0,
  parameter longint      MAX_V = 1
) (
  input  logic signed [IN_W-1:0] val_i,
  output logic [OUT_W-1:0]       val_o,
  output logic                   sat_o
);

  logic signed [63:0] v;

  assign v = {{(64 - IN_W){val_i[IN_W-1]}}, val_i};

  always_comb begin
    val_o = v[OUT_W-1:0];
    sat_o = 1'b0;
    if (v > MAX_V) begin
      val_o = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (v < MIN_V) begin
      val_o = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/dll_rate_update.sv
// Per-channel DLL code-rate update: two-stage PI loop filter over flop-array channel state.
module dll_rate_update
  import dll_rate_update_pkg::*;
#(
  parameter int          KP_SHIFT     = 2,
  parameter int          KI_SHIFT     = 6,
  parameter int unsigned NUM_CHANNELS = `NUM_CHANNELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result_ready,
  input  logic [CHAN_W-1:0] result_tag,
  input  logic [DPHI_W-1:0] delta_phase_increment,
  input  logic              aid_valid,
  input  logic [CHAN_W-1:0] aid_tag,
  input  logic [INC_W-1:0]  aid_inc,
  input  logic              aid_clear,
  output logic              upd_valid,
  output logic [CHAN_W-1:0] upd_tag,
  output logic [INC_W-1:0]  code_phase_inc,
  output logic              upd_sat
);

  logic [INC_W-1:0]  nominal_q [NUM_CHANNELS];
  logic [CORR_W-1:0] corr_q    [NUM_CHANNELS];

  s1_entry_t s1_d, s1_q;
  logic      s1_valid_d, s1_valid_q;

  logic              upd_valid_q, upd_sat_q;
  logic [CHAN_W-1:0] upd_tag_q;
  logic [INC_W-1:0]  inc_q;

  logic              res_ok, aid_ok;
  logic [CHAN_W-1:0] rd_idx;

  logic signed [DPHI_W-1:0] dphi_s, ki_s, kp_s;
  logic signed [CORR_W-1:0] corr_s;
  logic signed [CORR_W:0]   corr_sum;
  logic [CORR_W-1:0]        corr_new;
  logic signed [SUM_W-1:0]  sum;
  logic [INC_W-1:0]         inc_d;
  logic                     corr_sat, out_sat;

  assign res_ok = result_ready && (32'(result_tag) < NUM_CHANNELS);
  assign aid_ok = aid_valid && (32'(aid_tag) < NUM_CHANNELS);
  assign rd_idx = res_ok ? result_tag : '0;

  // Stage 1 capture: same-cycle aid beats forwarded corr, which beats the array
  always_comb begin
    s1_valid_d = res_ok;
    s1_d.tag   = result_tag;
    s1_d.dphi  = delta_phase_increment;
    s1_d.nom   = nominal_q[rd_idx];
    s1_d.corr  = corr_q[rd_idx];
    if (s1_valid_q && (s1_q.tag == result_tag))
      s1_d.corr = corr_new;
    if (aid_ok && (aid_tag == result_tag)) begin
      s1_d.nom = aid_inc;
      if (aid_clear)
        s1_d.corr = '0;
    end
  end

  assign dphi_s = s1_q.dphi;
  assign corr_s = s1_q.corr;
  assign ki_s   = dphi_s >>> KI_SHIFT;
  assign kp_s   = dphi_s >>> KP_SHIFT;

  assign corr_sum = {corr_s[CORR_W-1], corr_s}
                  + {{(CORR_W + 1 - DPHI_W){ki_s[DPHI_W-1]}}, ki_s};

  dll_rate_sat #(
    .IN_W  (CORR_W + 1),
    .OUT_W (CORR_W),
    .MIN_V (CORR_MIN_L),
    .MAX_V (CORR_MAX_L)
  ) u_corr_sat (
    .val_i (corr_sum),
    .val_o (corr_new),
    .sat_o (corr_sat)
  );

  assign sum = {{(SUM_W - INC_W){1'b0}}, s1_q.nom}
             + {{(SUM_W - CORR_W){corr_new[CORR_W-1]}}, corr_new}
             + {{(SUM_W - DPHI_W){kp_s[DPHI_W-1]}}, kp_s};

  dll_rate_sat #(
    .IN_W  (SUM_W),
    .OUT_W (INC_W),
    .MIN_V (INC_MIN_L),
    .MAX_V (INC_MAX_L)
  ) u_out_sat (
    .val_i (sum),
    .val_o (inc_d),
    .sat_o (out_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      upd_valid_q <= 1'b0;
      upd_tag_q   <= '0;
      inc_q       <= INC_NOM;
      upd_sat_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      upd_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        upd_tag_q <= s1_q.tag;
        inc_q     <= inc_d;
        // a saturated integrator always drives the sum out of range as well
        upd_sat_q <= out_sat | corr_sat;
      end
    end
  end

  // Aid writes follow the S2 write so an aid_clear on the same channel wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        nominal_q[i] <= INC_NOM;
        corr_q[i]    <= '0;
      end
    end else begin
      if (s1_valid_q)
        corr_q[s1_q.tag] <= corr_new;
      if (aid_ok) begin
        nominal_q[aid_tag] <= aid_inc;
        if (aid_clear)
          corr_q[aid_tag] <= '0;
      end
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_tag        = upd_tag_q;
  assign code_phase_inc = inc_q;
  assign upd_sat        = upd_sat_q;

endmodule
